sflash_seq: RTL and testbench

- Read-transaction sequencer that sits directly upstream of the byte-level SPI flash engine.
- Takes a read request (byte address, byte count, SDR or quad mode) and issues the full flash command one byte at a time over the engine's wr/ready/din/format/dout handshake.
- Returns read bytes on a valid/ready stream.
- Owns chip-select framing through the format code (000 = CS# high) and enforces a minimum CS# high time between transactions.

---
 rtl/sflash_seq.sv | 198 +++++++++++++++++++
 tb/tb_sflash_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sflash_seq.sv
// sflash_seq: read-transaction sequencer feeding a byte-level SPI flash engine.
// Builds the fast-read (1-1-1) or quad I/O read (1-4-4) command byte by byte.
// It returns the read bytes on a valid/ready stream. CS# framing is carried by
// f_format (000 = CS# high), with a minimum CS# high interval between transactions.
//
// state  | meaning
// IDLE   | waiting for a request; CS# high
// ISSUE  | present next byte, strobe f_wr once the engine is ready
// SKIP   | first cycle after f_wr, engine ready is still stale
// WAIT   | waiting for the engine to finish the byte in flight
// CSHI   | CS# high interval before returning to IDLE
module sflash_seq #(
    parameter int unsigned CSH_CYCLES = 4,
    parameter logic [7:0]  SDR_CMD    = 8'h0B,
    parameter logic [7:0]  QUAD_CMD   = 8'hEB
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        req,
    input  logic        quad,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    input  logic        abort,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        done,
    output logic        f_wr,
    output logic [7:0]  f_din,
    output logic [2:0]  f_format,
    input  logic        f_ready,
    input  logic [7:0]  f_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SKIP,
        S_WAIT,
        S_CSHI
    } state_t;

    localparam logic [3:0] CSH_LOAD = 4'(CSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic        quad_q, quad_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  csh_q, csh_d;
    logic        abort_q, abort_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        done_q, done_d;

    logic        is_data;
    logic        abort_pend;
    logic        can_issue;
    logic        accept;
    logic        in_txn;

    // Header is 5 bytes for fast read, 7 for quad I/O read; idx parks at the
    // header length while data bytes are being fetched.
    assign is_data    = (idx_q == (quad_q ? 3'd7 : 3'd5));
    assign abort_pend = abort_q | abort;
    // A data byte may only start once the previous one has been consumed.
    assign can_issue  = f_ready && !(is_data && rd_valid_q);
    // A req arriving in the done cycle is dropped so CS# high time stays honoured.
    assign accept     = (state_q == S_IDLE) && req && (len != 16'd0) && !done_q;
    assign in_txn     = (state_q == S_ISSUE) || (state_q == S_SKIP) || (state_q == S_WAIT);

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: begin
                if (abort_pend)     state_d = S_CSHI;
                else if (can_issue) state_d = S_SKIP;
            end
            S_SKIP:  state_d = S_WAIT;
            S_WAIT: begin
                if (f_ready) begin
                    if (abort_pend || (is_data && rem_q == 16'd1)) state_d = S_CSHI;
                    else                                           state_d = S_ISSUE;
                end
            end
            S_CSHI:  if (csh_q == 4'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: byte strobe, byte/format selection, busy.
    always_comb begin
        busy     = (state_q != S_IDLE);
        f_wr     = (state_q == S_ISSUE) && !abort_pend && can_issue;
        f_din    = 8'h00;
        f_format = 3'b000;
        if (in_txn) begin
            if (is_data) begin
                f_din    = 8'hFF;
                f_format = quad_q ? 3'b111 : 3'b011;
            end else begin
                case (idx_q)
                    3'd0: begin f_din = quad_q ? QUAD_CMD : SDR_CMD; f_format = 3'b010; end
                    3'd1: begin f_din = addr_q[23:16]; f_format = quad_q ? 3'b110 : 3'b010; end
                    3'd2: begin f_din = addr_q[15:8];  f_format = quad_q ? 3'b110 : 3'b010; end
                    3'd3: begin f_din = addr_q[7:0];   f_format = quad_q ? 3'b110 : 3'b010; end
                    3'd4: begin f_din = 8'h00;         f_format = quad_q ? 3'b110 : 3'b010; end
                    default: begin f_din = 8'hFF;      f_format = 3'b111; end
                endcase
            end
        end
    end

    // Datapath next values: request latch, byte counters, read stream, CS# timer.
    always_comb begin
        quad_d     = quad_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        csh_d      = csh_q;
        abort_d    = abort_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        done_d     = (state_q == S_CSHI) && (csh_q == 4'd0);

        if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;
        if (in_txn && abort) abort_d = 1'b0 | 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    quad_d  = quad;
                    addr_d  = addr;
                    rem_d   = len;
                    idx_d   = 3'd0;
                    abort_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (f_ready) begin
                    if (is_data) begin
                        rd_data_d  = f_dout;
                        rd_valid_d = 1'b1;
                        rem_d      = rem_q - 16'd1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_CSHI: begin
                abort_d = 1'b0;
                if (csh_q != 4'd0) csh_d = csh_q - 4'd1;
            end
            default: ;
        endcase

        if (state_d == S_CSHI && state_q != S_CSHI) csh_d = CSH_LOAD;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            quad_q     <= 1'b0;
            addr_q     <= 24'h0;
            rem_q      <= 16'h0;
            idx_q      <= 3'd0;
            csh_q      <= 4'd0;
            abort_q    <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            quad_q     <= quad_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            csh_q      <= csh_d;
            abort_q    <= abort_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sflash_seq.sv
// Testbench for sflash_seq: SPI engine model, byte-list scoreboard, read-stream checks.
module tb_sflash_seq;

    localparam int CSH = 4;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req = 1'b0;
    logic        quad = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [15:0] len = 16'h0;
    logic        abort = 1'b0;
    logic        busy;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        done;
    logic        f_wr;
    logic [7:0]  f_din;
    logic [2:0]  f_format;
    logic        f_ready = 1'b1;
    logic [7:0]  f_dout = 8'h00;

    sflash_seq #(.CSH_CYCLES(CSH), .SDR_CMD(8'h0B), .QUAD_CMD(8'hEB)) dut (
        .clk(clk), .arstn(arstn), .req(req), .quad(quad), .addr(addr), .len(len),
        .abort(abort), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .done(done), .f_wr(f_wr), .f_din(f_din),
        .f_format(f_format), .f_ready(f_ready), .f_dout(f_dout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] din;
        logic [2:0] fmt;
        logic       data;
    } wr_t;

    typedef struct {
        bit          quad;
        logic [23:0] addr;
        logic [15:0] len;
        int          abort_at;
        bit          mid_req;
        bit          bp;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    wr_t        exp_q[$];
    logic [7:0] rd_exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, cshi_cnt = 0, busy_cnt = 0, stab_err = 0;
    logic busy_at_done = 1'b1;
    logic [7:0] prev_din = 8'h00;
    logic [2:0] prev_fmt = 3'b000;

    // SPI engine model: ready drops one cycle after f_wr, byte takes 3 more cycles.
    logic [7:0] dout_next = 8'h3C;
    int  eng_cnt = 0;
    bit  eng_pend = 1'b0;
    always @(posedge clk) begin
        if (eng_cnt != 0) begin
            if (eng_cnt == 1) begin
                f_ready   <= 1'b1;
                f_dout    <= dout_next;
                dout_next <= dout_next + 8'h1D;
            end
            eng_cnt <= eng_cnt - 1;
        end else if (eng_pend) begin
            eng_pend <= 1'b0;
            f_ready  <= 1'b0;
            eng_cnt  <= 3;
        end
        if (f_wr) eng_pend <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard f_wr bytes, consume read stream, count framing events.
    always @(negedge clk) begin
        if (arstn) begin
            if (f_wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_extra", exp_q.size(), 1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_din", {24'h0, f_din}, {24'h0, e.din});
                    chk("wr_fmt", {29'h0, f_format}, {29'h0, e.fmt});
                    if (e.data) rd_exp_q.push_back(dout_next);
                end
            end
            if (rd_valid && rd_ready) begin
                rd_cnt++;
                if (rd_exp_q.size() == 0) chk("rd_extra", rd_exp_q.size(), 1);
                else chk("rd_data", {24'h0, rd_data}, {24'h0, rd_exp_q.pop_front()});
            end
            if (done) begin
                done_cnt++;
                busy_at_done = busy;
            end
            if (busy && f_format == 3'b000) cshi_cnt++;
            if (busy) busy_cnt++;
            if (!f_ready && (f_din != prev_din || f_format != prev_fmt)) stab_err++;
        end
        prev_din = f_din;
        prev_fmt = f_format;
    end

    task automatic build(input bit q, input logic [23:0] a, input logic [15:0] n);
        exp_q.delete();
        rd_exp_q.delete();
        if (!q) begin
            exp_q.push_back('{8'h0B, 3'b010, 1'b0});
            exp_q.push_back('{a[23:16], 3'b010, 1'b0});
            exp_q.push_back('{a[15:8], 3'b010, 1'b0});
            exp_q.push_back('{a[7:0], 3'b010, 1'b0});
            exp_q.push_back('{8'h00, 3'b010, 1'b0});
            for (int i = 0; i < int'(n); i++) exp_q.push_back('{8'hFF, 3'b011, 1'b1});
        end else begin
            exp_q.push_back('{8'hEB, 3'b010, 1'b0});
            exp_q.push_back('{a[23:16], 3'b110, 1'b0});
            exp_q.push_back('{a[15:8], 3'b110, 1'b0});
            exp_q.push_back('{a[7:0], 3'b110, 1'b0});
            exp_q.push_back('{8'h00, 3'b110, 1'b0});
            exp_q.push_back('{8'hFF, 3'b111, 1'b0});
            exp_q.push_back('{8'hFF, 3'b111, 1'b0});
            for (int i = 0; i < int'(n); i++) exp_q.push_back('{8'hFF, 3'b111, 1'b1});
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0; cshi_cnt = 0; busy_cnt = 0; stab_err = 0;
        busy_at_done = 1'b1;
    endtask

    task automatic run_txn(input vec_t v);
        int  w0, fmt_bad, cyc;
        bit  bp_done, ab_done;
        build(v.quad, v.addr, v.len);
        clear_counts();
        rd_ready = !v.bp;
        @(posedge clk); #1;
        req = 1'b1; quad = v.quad; addr = v.addr; len = v.len;
        @(posedge clk); #1;
        req = 1'b0;
        chk("busy_after_req", {31'h0, busy}, 1);
        cyc = 0; bp_done = 1'b0; ab_done = 1'b0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            abort = 1'b0;
            req   = 1'b0;
            if (v.abort_at >= 0 && !ab_done && wr_cnt == v.abort_at + 1) begin
                abort = 1'b1; ab_done = 1'b1;
            end
            if (v.mid_req && cyc == 12) begin
                req = 1'b1; addr = 24'hFFFFFF; len = 16'd9; quad = ~v.quad;
            end
            if (v.bp && !bp_done && rd_valid) begin
                w0 = wr_cnt; fmt_bad = 0;
                repeat (50) begin
                    @(posedge clk); #1;
                    if (f_format !== 3'b011) fmt_bad++;
                end
                chk("bp_no_wr", wr_cnt, w0);
                chk("bp_fmt_011", fmt_bad, 0);
                rd_ready = 1'b1; bp_done = 1'b1;
            end
        end
        abort = 1'b0; req = 1'b0;
        @(posedge clk); #1;
        chk("n_wr", wr_cnt, v.exp_wr);
        chk("n_rd", rd_cnt, v.exp_rd);
        chk("done_once", done_cnt, 1);
        chk("cs_high_cycles", cshi_cnt, CSH);
        chk("busy_at_done", {31'h0, busy_at_done}, 0);
        chk("rd_left", rd_exp_q.size(), 0);
        chk("fmt_din_stable", stab_err, 0);
        chk("busy_end", {31'h0, busy}, 0);
        chk("fmt_end", {29'h0, f_format}, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int cyc;
        vecs[0] = '{1'b0, 24'h012345, 16'd2, -1, 1'b0, 1'b0, 7, 2};
        vecs[1] = '{1'b1, 24'h000100, 16'd1, -1, 1'b0, 1'b0, 8, 1};
        vecs[2] = '{1'b0, 24'hABCDEF, 16'd1, -1, 1'b1, 1'b0, 6, 1};
        vecs[3] = '{1'b1, 24'h123456, 16'd3, -1, 1'b0, 1'b0, 10, 3};
        vecs[4] = '{1'b0, 24'h012345, 16'd4, 2, 1'b0, 1'b0, 3, 0};
        vecs[5] = '{1'b0, 24'h000010, 16'd3, -1, 1'b0, 1'b1, 8, 3};

        // Reset state.
        #12;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 0);
        chk("rst_rd_data", {24'h0, rd_data}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_f_wr", {31'h0, f_wr}, 0);
        chk("rst_f_din", {24'h0, f_din}, 0);
        chk("rst_f_format", {29'h0, f_format}, 0);
        @(posedge clk); #1;
        arstn = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) run_txn(vecs[i]);

        // len = 0 request is ignored.
        clear_counts();
        @(posedge clk); #1;
        req = 1'b1; quad = 1'b0; addr = 24'h000055; len = 16'd0;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("len0_wr", wr_cnt, 0);
        chk("len0_busy", busy_cnt, 0);
        chk("len0_done", done_cnt, 0);

        // Reset while the first data byte is in flight.
        build(1'b0, 24'h000000, 16'd2);
        clear_counts();
        rd_ready = 1'b1;
        @(posedge clk); #1;
        req = 1'b1; quad = 1'b0; addr = 24'h000000; len = 16'd2;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 0;
        while (wr_cnt < 6 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_reach_data", wr_cnt, 6);
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'h0, busy}, 1);
        chk("pre_rst_fmt", {29'h0, f_format}, 3'b011);
        arstn = 1'b0;
        #2;
        chk("arst_fmt", {29'h0, f_format}, 0);
        chk("arst_rd_valid", {31'h0, rd_valid}, 0);
        chk("arst_busy", {31'h0, busy}, 0);
        chk("arst_f_wr", {31'h0, f_wr}, 0);
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        exp_q.delete();
        rd_exp_q.delete();
        run_txn(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
